// File: rtl/sc_shiftrow_controller_if.sv
// Button, edge-flag and command bundle between the game datapath stimulus side
// and the shift-row sequencing FSM.
interface sc_shiftrow_controller_if #(
    parameter int DATAWIDTH       = 8,
    parameter int MOVECOUNT_WIDTH = 8
);
    logic                       SC_SHIFTROW_CONTROLLER_startButton_InLow;
    logic                       SC_SHIFTROW_CONTROLLER_leftButton_InLow;
    logic                       SC_SHIFTROW_CONTROLLER_rightButton_InLow;
    logic                       SC_SHIFTROW_CONTROLLER_bottomsideLeft_InHigh;
    logic                       SC_SHIFTROW_CONTROLLER_bottomsideRight_InHigh;
    logic [1:0]                 SC_SHIFTROW_CONTROLLER_shiftSelection_OutBUS;
    logic [DATAWIDTH-1:0]       SC_SHIFTROW_CONTROLLER_loadData_OutBUS;
    logic [MOVECOUNT_WIDTH-1:0] SC_SHIFTROW_CONTROLLER_moveCount_OutBUS;
    logic                       SC_SHIFTROW_CONTROLLER_edgeHit_OutHigh;

    modport master (
        output SC_SHIFTROW_CONTROLLER_startButton_InLow,
        output SC_SHIFTROW_CONTROLLER_leftButton_InLow,
        output SC_SHIFTROW_CONTROLLER_rightButton_InLow,
        output SC_SHIFTROW_CONTROLLER_bottomsideLeft_InHigh,
        output SC_SHIFTROW_CONTROLLER_bottomsideRight_InHigh,
        input  SC_SHIFTROW_CONTROLLER_shiftSelection_OutBUS,
        input  SC_SHIFTROW_CONTROLLER_loadData_OutBUS,
        input  SC_SHIFTROW_CONTROLLER_moveCount_OutBUS,
        input  SC_SHIFTROW_CONTROLLER_edgeHit_OutHigh
    );

    modport slave (
        input  SC_SHIFTROW_CONTROLLER_startButton_InLow,
        input  SC_SHIFTROW_CONTROLLER_leftButton_InLow,
        input  SC_SHIFTROW_CONTROLLER_rightButton_InLow,
        input  SC_SHIFTROW_CONTROLLER_bottomsideLeft_InHigh,
        input  SC_SHIFTROW_CONTROLLER_bottomsideRight_InHigh,
        output SC_SHIFTROW_CONTROLLER_shiftSelection_OutBUS,
        output SC_SHIFTROW_CONTROLLER_loadData_OutBUS,
        output SC_SHIFTROW_CONTROLLER_moveCount_OutBUS,
        output SC_SHIFTROW_CONTROLLER_edgeHit_OutHigh
    );
endinterface

// File: rtl/sc_shiftrow_controller.sv
// Sequencing FSM for one LED-matrix row register: turns active-low buttons into
// one-cycle load/left/right commands, blocks edge moves and counts accepted moves.
module sc_shiftrow_controller #(
    parameter int                   DATAWIDTH       = 8,
    parameter logic [DATAWIDTH-1:0] INIT_PATTERN    = 8'b00010000,
    parameter int                   MOVECOUNT_WIDTH = 8
) (
    input logic                     SC_SHIFTROW_CONTROLLER_CLOCK_50,
    input logic                     SC_SHIFTROW_CONTROLLER_RESET_InLow,
    sc_shiftrow_controller_if.slave bus
);
    typedef enum logic [2:0] {
        S_INIT,
        S_LOAD,
        S_IDLE,
        S_LEFT,
        S_RIGHT,
        S_SETTLE
    } state_t;

    state_t                     state;
    state_t                     next_state;
    logic [1:0]                 sel_next;
    logic                       edge_next;
    logic [2:0]                 start_sync;
    logic [2:0]                 left_sync;
    logic [2:0]                 right_sync;
    logic                       start_press;
    logic                       left_press;
    logic                       right_press;
    logic [1:0]                 shift_sel;
    logic [DATAWIDTH-1:0]       load_data;
    logic [MOVECOUNT_WIDTH-1:0] move_count;
    logic                       edge_hit;

    // Two sync flops then a third delayed copy; the press pulse is registered,
    // which puts the FSM transition three edges after the first low sample.
    always_ff @(posedge SC_SHIFTROW_CONTROLLER_CLOCK_50 or negedge SC_SHIFTROW_CONTROLLER_RESET_InLow) begin
        if (!SC_SHIFTROW_CONTROLLER_RESET_InLow) begin
            start_sync  <= 3'b111;
            left_sync   <= 3'b111;
            right_sync  <= 3'b111;
            start_press <= 1'b0;
            left_press  <= 1'b0;
            right_press <= 1'b0;
        end else begin
            start_sync  <= {start_sync[1:0], bus.SC_SHIFTROW_CONTROLLER_startButton_InLow};
            left_sync   <= {left_sync[1:0],  bus.SC_SHIFTROW_CONTROLLER_leftButton_InLow};
            right_sync  <= {right_sync[1:0], bus.SC_SHIFTROW_CONTROLLER_rightButton_InLow};
            start_press <= start_sync[2] & ~start_sync[1];
            left_press  <= left_sync[2]  & ~left_sync[1];
            right_press <= right_sync[2] & ~right_sync[1];
        end
    end

    always_comb begin
        next_state = state;
        sel_next   = 2'b00;
        edge_next  = 1'b0;
        case (state)
            S_INIT:  next_state = S_LOAD;
            S_LOAD:  next_state = S_SETTLE;
            S_IDLE: begin
                if (start_press) begin
                    next_state = S_LOAD;
                end else if (left_press && right_press) begin
                    next_state = S_IDLE;
                end else if (left_press) begin
                    if (bus.SC_SHIFTROW_CONTROLLER_bottomsideLeft_InHigh) edge_next = 1'b1;
                    else next_state = S_LEFT;
                end else if (right_press) begin
                    if (bus.SC_SHIFTROW_CONTROLLER_bottomsideRight_InHigh) edge_next = 1'b1;
                    else next_state = S_RIGHT;
                end
            end
            S_LEFT:   next_state = S_SETTLE;
            S_RIGHT:  next_state = S_SETTLE;
            S_SETTLE: next_state = S_IDLE;
            default:  next_state = S_INIT;
        endcase
        case (next_state)
            S_LOAD:  sel_next = 2'b01;
            S_LEFT:  sel_next = 2'b10;
            S_RIGHT: sel_next = 2'b11;
            default: sel_next = 2'b00;
        endcase
    end

    // Outputs are registered alongside the state so they line up with it.
    always_ff @(posedge SC_SHIFTROW_CONTROLLER_CLOCK_50 or negedge SC_SHIFTROW_CONTROLLER_RESET_InLow) begin
        if (!SC_SHIFTROW_CONTROLLER_RESET_InLow) begin
            state      <= S_INIT;
            shift_sel  <= 2'b00;
            load_data  <= '0;
            move_count <= '0;
            edge_hit   <= 1'b0;
        end else begin
            state     <= next_state;
            shift_sel <= sel_next;
            edge_hit  <= edge_next;
            if (next_state == S_LOAD) begin
                load_data  <= INIT_PATTERN;
                move_count <= '0;
            end else if ((next_state == S_LEFT) || (next_state == S_RIGHT)) begin
                if (move_count != '1) move_count <= move_count + MOVECOUNT_WIDTH'(1);
            end
        end
    end

    assign bus.SC_SHIFTROW_CONTROLLER_shiftSelection_OutBUS = shift_sel;
    assign bus.SC_SHIFTROW_CONTROLLER_loadData_OutBUS       = load_data;
    assign bus.SC_SHIFTROW_CONTROLLER_moveCount_OutBUS      = move_count;
    assign bus.SC_SHIFTROW_CONTROLLER_edgeHit_OutHigh       = edge_hit;
endmodule
